// File: rtl/echo_delay_fb.sv
// Feedback echo/delay with programmable length, feedback gain and wet mix.
// One sample per four cycles; the circular buffer is cleared after every reset.
module echo_delay_fb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 20000,
    parameter int GAIN_WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic                         in_ready,
    input  logic        [ADDR_WIDTH-1:0] delay_len,
    input  logic        [GAIN_WIDTH-1:0] fb_gain,
    input  logic        [GAIN_WIDTH-1:0] mix,
    input  logic                         bypass,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         y_valid
);
    // state | meaning
    // CLEAR | zero the buffer, one entry per cycle
    // IDLE  | wait for an accepted sample, read issued on accept
    // RD    | RAM read data settles
    // MAC   | register feedback and mix products
    // WR    | write echo back, update y

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int MW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {CLEAR, IDLE, RD, MAC, WR} state_t;

    state_t                         state;
    logic        [ADDR_WIDTH-1:0]   clr_addr;
    logic        [ADDR_WIDTH-1:0]   wp;
    logic        [ADDR_WIDTH-1:0]   rd_addr;
    logic        [ADDR_WIDTH:0]     len_l;
    logic        [ADDR_WIDTH:0]     len_new;
    logic signed [DATA_WIDTH-1:0]   x_l;
    logic                           byp_l;
    logic        [GAIN_WIDTH-1:0]   fb_l;
    logic        [GAIN_WIDTH-1:0]   mix_l;
    logic signed [DATA_WIDTH-1:0]   rd_data;
    logic signed [PW-1:0]           d_ext;
    logic signed [PW-1:0]           fb_ext;
    logic signed [PW-1:0]           mix_ext;
    logic signed [PW-1:0]           pf;
    logic signed [PW-1:0]           pm;
    logic signed [DATA_WIDTH-1:0]   w;
    logic                           accept;
    logic                           mem_we;
    logic        [ADDR_WIDTH-1:0]   mem_waddr;
    logic signed [DATA_WIDTH-1:0]   mem_wdata;
    logic signed [DATA_WIDTH-1:0]   mem [DEPTH];

    // a + (p >>> GAIN_WIDTH), summed one bit wider, then clamped
    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [PW-1:0]         p
    );
        logic signed [DATA_WIDTH:0] sh;
        logic signed [DATA_WIDTH:0] s;
        sh = (DATA_WIDTH + 1)'(p >>> GAIN_WIDTH);
        s  = {a[DATA_WIDTH-1], a} + sh;
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sat_add = s[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        if (delay_len == '0)
            len_new = (ADDR_WIDTH + 1)'(1);
        else if ({1'b0, delay_len} > DEPTH_L)
            len_new = DEPTH_L;
        else
            len_new = {1'b0, delay_len};
        rd_addr = ({1'b0, wp} >= len_new) ? '0 : wp;
    end

    assign in_ready  = (state == IDLE) && en;
    assign accept    = in_ready && x_valid;
    assign d_ext     = {{(GAIN_WIDTH + 1){rd_data[DATA_WIDTH-1]}}, rd_data};
    assign fb_ext    = {{(DATA_WIDTH + 1){1'b0}}, fb_l};
    assign mix_ext   = {{(DATA_WIDTH + 1){1'b0}}, mix_l};
    assign w         = sat_add(x_l, pf);
    assign mem_we    = (state == CLEAR) || (state == WR);
    assign mem_waddr = (state == CLEAR) ? clr_addr : wp;
    assign mem_wdata = (state == CLEAR) ? '0 : w;

    // Buffer RAM: one write port, one synchronous read port
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[MW'(mem_waddr)] <= mem_wdata;
        if (accept)
            rd_data <= mem[MW'(rd_addr)];
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            wp       <= '0;
            len_l    <= (ADDR_WIDTH + 1)'(1);
            x_l      <= '0;
            byp_l    <= 1'b0;
            fb_l     <= '0;
            mix_l    <= '0;
            pf       <= '0;
            pm       <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= '0;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        x_l   <= x;
                        byp_l <= bypass;
                        fb_l  <= fb_gain;
                        mix_l <= mix;
                        len_l <= len_new;
                        wp    <= rd_addr;
                        state <= RD;
                    end
                end
                RD: state <= MAC;
                MAC: begin
                    pf    <= d_ext * fb_ext;
                    pm    <= d_ext * mix_ext;
                    state <= WR;
                end
                WR: begin
                    y       <= byp_l ? x_l : sat_add(x_l, pm);
                    y_valid <= 1'b1;
                    wp      <= ({1'b0, wp} == len_l - 1'b1) ? '0 : wp + 1'b1;
                    state   <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_fb.sv
// Directed bench for echo_delay_fb: scoreboard of expected y per accepted
// sample, plus fixed expected values for the impulse, saturation and boundary cases.
module tb_echo_delay_fb;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int GW    = 8;

    logic                 CLK = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 x_valid = 1'b0;
    logic                 bypass = 1'b0;
    logic signed [DW-1:0] x = '0;
    logic        [AW-1:0] delay_len = '0;
    logic        [GW-1:0] fb_gain = '0;
    logic        [GW-1:0] mix = '0;
    logic                 in_ready;
    logic                 y_valid;
    logic signed [DW-1:0] y;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mem_m[DEPTH];
    int wp_m = 0;

    echo_delay_fb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .GAIN_WIDTH(GW)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .en(en),
        .x_valid(x_valid),
        .x(x),
        .in_ready(in_ready),
        .delay_len(delay_len),
        .fb_gain(fb_gain),
        .mix(mix),
        .bypass(bypass),
        .y(y),
        .y_valid(y_valid)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Behavioural reference: floor division of products by 256, clamp to 16 bits
    function automatic int ref_model(input int xv, input bit byp, input int fb,
                                     input int mx, input int dl);
        int len;
        int d;
        int wv;
        int yv;
        len = (dl == 0) ? 1 : ((dl > DEPTH) ? DEPTH : dl);
        if (wp_m >= len) wp_m = 0;
        d  = mem_m[wp_m];
        wv = sat16(xv + ((d * fb) >>> GW));
        yv = byp ? xv : sat16(xv + ((d * mx) >>> GW));
        mem_m[wp_m] = wv;
        wp_m = (wp_m == len - 1) ? 0 : wp_m + 1;
        return yv;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_y_at_reset"}, y, 0);
        chk({tag, "_valid_at_reset"}, y_valid, 0);
        chk({tag, "_ready_at_reset"}, in_ready, 0);
        repeat (2) begin
            step();
            chk({tag, "_valid_in_reset"}, y_valid, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, "_clear_ready"}, in_ready, 0);
            chk({tag, "_clear_valid"}, y_valid, 0);
            chk({tag, "_clear_y"}, y, 0);
            step();
        end
        chk({tag, "_ready_after_clear"}, in_ready, 1);
        foreach (mem_m[i]) mem_m[i] = 0;
        wp_m = 0;
        exp_q.delete();
    endtask

    task automatic send(input int xv, input bit byp, input int fb, input int mx,
                        input int dl, input bit hold, input bit drop_en,
                        output int y_obs);
        int e;
        en        = 1'b1;
        x         = DW'(xv);
        bypass    = byp;
        fb_gain   = GW'(fb);
        mix       = GW'(mx);
        delay_len = AW'(dl);
        x_valid   = 1'b1;
        #1;
        chk("accept_ready", in_ready, 1);
        exp_q.push_back(ref_model(xv, byp, fb, mx, dl));
        step();
        if (!hold) x_valid = 1'b0;
        if (drop_en) en = 1'b0;
        y_obs = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) begin
                chk("early_valid", y_valid, 0);
            end else begin
                chk("latency_valid", y_valid, 1);
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("y_scoreboard", y, e);
                end
                y_obs = y;
            end
        end
        x_valid = 1'b0;
        en      = 1'b1;
    endtask

    initial begin
        int yo;
        int imp[13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
        int satv[4] = '{29999, 32767, 32767, 32767};
        int bpx[3]  = '{123, -456, 7};
        int echo[3] = '{122, -455, 6};
        int shr[5]  = '{11, 22, 33, 44, 55};

        en = 1'b1;
        #2;
        // Clear sequence after reset
        do_reset("clear");

        // Impulse echo, half feedback and half mix
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 1000 : 0, 1'b0, 128, 128, 4, 1'b0, 1'b0, yo);
            chk("impulse", yo, imp[i]);
        end

        // Negative rounding toward -inf
        do_reset("neg");
        send(-1, 1'b0, 128, 128, 1, 1'b0, 1'b0, yo);
        chk("neg_first", yo, -1);
        send(0, 1'b0, 128, 128, 1, 1'b0, 1'b0, yo);
        chk("neg_round", yo, -1);

        // Saturation of y and of the stored echo
        for (int i = 0; i < 4; i++) begin
            send(30000, 1'b0, 255, 255, 1, 1'b0, 1'b0, yo);
            chk("sat_y", yo, satv[i]);
        end
        send(0, 1'b0, 255, 255, 1, 1'b0, 1'b0, yo);
        chk("sat_stored_w", yo, 32639);

        // Bypass still feeds the buffer
        do_reset("byp");
        for (int i = 0; i < 3; i++) begin
            send(bpx[i], 1'b1, 128, 128, 3, 1'b0, 1'b0, yo);
            chk("bypass_y", yo, bpx[i]);
        end
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b0, 128, 255, 3, 1'b0, 1'b0, yo);
            chk("bypass_echo", yo, echo[i]);
        end

        // delay_len = 0 acts as 1
        do_reset("len0");
        send(1000, 1'b0, 128, 128, 0, 1'b0, 1'b0, yo);
        chk("len0_a", yo, 1000);
        send(0, 1'b0, 128, 128, 0, 1'b0, 1'b0, yo);
        chk("len0_b", yo, 500);
        send(0, 1'b0, 128, 128, 0, 1'b0, 1'b0, yo);
        chk("len0_c", yo, 250);

        // delay_len above DEPTH clamps to DEPTH
        do_reset("len31");
        for (int i = 0; i <= 16; i++) begin
            send((i == 0) ? 1000 : 0, 1'b0, 128, 128, 31, 1'b0, 1'b0, yo);
            if (i == 15) chk("len31_before", yo, 0);
            if (i == 16) chk("len31_echo", yo, 500);
        end

        // Shrinking delay_len wraps wp to 0
        do_reset("shrink");
        for (int i = 0; i < 5; i++) begin
            send(shr[i], 1'b0, 128, 128, 8, 1'b0, 1'b0, yo);
            chk("shrink_fill", yo, shr[i]);
        end
        send(0, 1'b0, 128, 128, 2, 1'b0, 1'b0, yo);
        chk("shrink_wrap0", yo, 5);
        send(0, 1'b0, 128, 128, 2, 1'b0, 1'b0, yo);
        chk("shrink_wrap1", yo, 11);

        // Handshake: x_valid while busy or with en=0 is ignored
        do_reset("hs");
        send(1000, 1'b0, 128, 128, 4, 1'b1, 1'b0, yo);
        chk("hold_valid_y", yo, 1000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_extra_valid", y_valid, 0);
        end
        en      = 1'b0;
        x       = DW'(555);
        x_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("en0_ready", in_ready, 0);
            chk("en0_valid", y_valid, 0);
            step();
        end
        x_valid = 1'b0;
        en      = 1'b1;
        send(0, 1'b0, 128, 128, 4, 1'b0, 1'b1, yo);
        send(1000, 1'b1, 128, 128, 4, 1'b0, 1'b0, yo);
        chk("pre_abort_y", yo, 1000);

        // Reset during MAC aborts the in-flight sample
        x       = DW'(77);
        bypass  = 1'b0;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        step();
        do_reset("rst_mac");
        send(0, 1'b0, 128, 128, 4, 1'b0, 1'b0, yo);
        chk("after_abort_y", yo, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_delay_fb.md
Name: echo_delay_fb

Overview:
- Parametrised feedback echo/delay effect for the guitar signal path; next generation of the fixed half-gain delay.
- Adds a runtime-programmable delay length, feedback gain and wet mix, a per-sample valid/ready handshake, bypass, saturation and automatic buffer clearing.
- Sits between the ADC sample stream and downstream effects; the circular buffer is an internal single-clock RAM with synchronous read.

Parameters:
DATA_WIDTH, 32, signed two's-complement sample width
ADDR_WIDTH, 15, buffer address width
DEPTH, 20000, buffer entries (DEPTH <= 2^ADDR_WIDTH)
GAIN_WIDTH, 8, unsigned gain width; gain g means g/2^GAIN_WIDTH

Ports:
CLK  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
en  input  1  1 = accept samples; 0 = in_ready low, outputs hold
x_valid  input  1  input sample strobe
x  input  DATA_WIDTH  signed input sample
in_ready  output  1  block can accept a sample this cycle
delay_len  input  ADDR_WIDTH  delay in samples
fb_gain  input  GAIN_WIDTH  feedback gain
mix  input  GAIN_WIDTH  wet gain applied to delayed sample
bypass  input  1  1 = y equals x
y  output  DATA_WIDTH  signed output sample
y_valid  output  1  one-cycle pulse when y updates

Behaviour:
- Reset (async, rst=0): state CLEAR, clear address 0, wp=0, y=0, y_valid=0, in_ready=0. Asserting reset mid-sample aborts that sample; no y_valid for it.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle. in_ready=0 throughout. Exactly DEPTH cycles after reset release, go to IDLE.
- IDLE: in_ready = en.
  - On x_valid & en: latch x, bypass, fb_gain, mix and L. L = 1 if delay_len==0; DEPTH if delay_len>DEPTH; else delay_len.
  - If wp >= L, wp is reset to 0 first.
  - Issue read at wp; go to RD.
  - x_valid while in_ready=0 is ignored. No queueing.
- RD: RAM returns d = mem[wp] (the sample written L accepted samples ago); go to MAC.
- MAC: register products pf = d*fb_gain and pm = d*mix at full precision (DATA_WIDTH+GAIN_WIDTH+1 signed); go to WR.
- WR:
  - w = sat(x + (pf >>> GAIN_WIDTH)) is written to mem[wp].
  - y <= bypass ? x : sat(x + (pm >>> GAIN_WIDTH)); y_valid=1 for this cycle only.
  - wp <= (wp == L-1) ? 0 : wp+1. Go to IDLE.
- Latency: accept at edge N, y/y_valid registered at edge N+3. Maximum throughput is 1 sample per 4 cycles.
- Arithmetic:
  - >>> is an arithmetic shift (rounds toward -inf).
  - sat() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Additions are done at DATA_WIDTH+1 bits before clamping.
- Bypass still updates the buffer with w, so echoes continue when bypass is released.
- en=0 in a non-IDLE state: the in-flight sample completes normally.
- A delay_len change takes effect at the next accepted sample. Buffer contents are not cleared on change.
- y holds its last value between y_valid pulses.

Test Plan:
(bench: DATA_WIDTH=16, ADDR_WIDTH=5, DEPTH=16, GAIN_WIDTH=8)
1. Clear:
   - Stimulus: release reset.
   - Required: in_ready=0 for exactly 16 cycles, then 1 (en=1); y=0, y_valid=0 throughout.
2. Impulse echo:
   - Stimulus: delay_len=4, fb_gain=128, mix=128; x=1000 then zeros, one sample every 4 cycles.
   - Required: y = 1000,0,0,0,500,0,0,0,250,0,0,0,125; each y_valid exactly 3 cycles after accept.
3. Negative rounding and saturation:
   - Stimulus A: delay_len=1, fb_gain=128, mix=128; x=-1 then 0.
   - Required A: second y = -1.
   - Stimulus B: delay_len=1, fb_gain=255, mix=255; x=30000 repeated.
   - Required B: y saturates to 32767 by the second sample and stays there; stored w also clamps to 32767.
4. Bypass:
   - Stimulus: bypass=1, x = 123, -456, 7.
   - Required: y equals x at 3-cycle latency.
   - Then bypass=0, delay_len=3, mix=255, x=0: y reflects the stored echo (w values written during bypass).
5. Length boundaries:
   - delay_len=0 behaves identically to 1.
   - delay_len=31 behaves as 16 (impulse reappears at sample 16).
   - Shrinking delay_len from 8 to 2 with wp=5: wp wraps to 0 on the next accept.
6. Handshake and reset:
   - x_valid pulses during RD/MAC/WR or with en=0 produce no extra y_valid.
   - rst asserted during MAC: y=0 immediately, no y_valid, CLEAR restarts for 16 cycles.
